// File: rtl/mips16_cpu.sv
// mips16_cpu: 16-bit MIPS-style multicycle core sharing one word-addressed,
// synchronous memory port between instruction fetch and load/store.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   addr_tb    memory word address (PC on fetch, effective address on MEM)
//   mem_en     memory access enable
//   mem_read   read strobe (fetch or LW), qualified by mem_en
//   mem_write  write strobe (SW), qualified by mem_en
//   dout_cpu   store data (rt of SW), zero otherwise
//   din_cpu    read data, valid the cycle after the read strobe
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | drive PC with a read strobe (idles here until first clock
//          | after reset release)
// S_DECODE | capture instruction from din_cpu, PC <= PC+1
// S_EXEC   | ALU / effective address / branch and jump resolution
// S_MEM    | LW read or SW write at the computed address
// S_WB     | register write (ALU result, or din_cpu for LW)
// S_HALT   | no memory activity until reset

module mips16_cpu #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr_tb,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] dout_cpu,
  input  logic [DATA_W-1:0] din_cpu
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  // Field slices shared by all formats: every format places its operands in
  // the same three nibbles, only their roles differ.
  logic [3:0] op, f_hi, f_mid, f_lo;
  assign op    = ir_q[15:12];
  assign f_hi  = ir_q[11:8];
  assign f_mid = ir_q[7:4];
  assign f_lo  = ir_q[3:0];

  // r0 is never written, so reading the array directly yields zero for it.
  logic [DATA_W-1:0] r_hi, r_mid, r_lo;
  assign r_hi  = regs_q[f_hi];
  assign r_mid = regs_q[f_mid];
  assign r_lo  = regs_q[f_lo];

  logic [DATA_W-1:0] sext8, sext4, ea;
  logic [ADDR_W-1:0] br_off;
  assign sext8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sext4  = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
  assign br_off = {{(ADDR_W-4){ir_q[3]}}, ir_q[3:0]};
  assign ea     = r_mid + sext4;

  // Destination is always the [11:8] nibble (rd for R-type, rt for ADDI/LW).
  logic [DATA_W-1:0] wb_data;
  assign wb_data = (op == OP_LW) ? din_cpu : alu_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && f_hi != 4'd0) begin
      regs_q[f_hi] <= wb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    case (state_q)
      // The first clock after reset release only arms run_q, so the first
      // real fetch cycle starts on that edge.
      S_FETCH: if (run_q) state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = din_cpu;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD:  begin alu_d = r_mid + r_lo; state_d = S_WB; end
          OP_SUB:  begin alu_d = r_mid - r_lo; state_d = S_WB; end
          OP_AND:  begin alu_d = r_mid & r_lo; state_d = S_WB; end
          OP_OR:   begin alu_d = r_mid | r_lo; state_d = S_WB; end
          OP_XOR:  begin alu_d = r_mid ^ r_lo; state_d = S_WB; end
          OP_SLT: begin
            alu_d   = {{(DATA_W-1){1'b0}}, ($signed(r_mid) < $signed(r_lo))};
            state_d = S_WB;
          end
          OP_SLL:  begin alu_d = r_mid << r_lo[3:0]; state_d = S_WB; end
          OP_SRL:  begin alu_d = r_mid >> r_lo[3:0]; state_d = S_WB; end
          OP_ADDI: begin alu_d = r_hi + sext8; state_d = S_WB; end
          OP_LW, OP_SW: begin alu_d = ea; state_d = S_MEM; end
          // pc_q already points past the branch here.
          OP_BEQ:  if (r_hi == r_mid) pc_d = pc_q + br_off;
          OP_BNE:  if (r_hi != r_mid) pc_d = pc_q + br_off;
          OP_JMP:  pc_d = ir_q[ADDR_W-1:0];
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM:   state_d = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs; run_q keeps everything quiet while in reset and until the
  // first fetch cycle, and drops the strobes immediately on reset assertion.
  always_comb begin
    addr_tb   = '0;
    mem_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    dout_cpu  = '0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          addr_tb  = pc_q;
          mem_en   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM: begin
          addr_tb   = alu_q[ADDR_W-1:0];
          mem_en    = 1'b1;
          mem_read  = (op == OP_LW);
          mem_write = (op == OP_SW);
          if (op == OP_SW) dout_cpu = r_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_cpu.sv
module tb_mips16_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr_tb;
  logic        mem_en, mem_read, mem_write;
  logic [15:0] dout_cpu;
  logic [15:0] din_cpu;

  logic [15:0] mem [0:4095];
  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] fetch_adr [16];
  int          fetch_cyc [16];

  logic [15:0] alu_prog [29];
  logic [11:0] exp_wa   [13];
  logic [15:0] exp_wd   [13];

  mips16_cpu #(.ADDR_W(12), .DATA_W(16), .NREGS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr_tb   (addr_tb),
    .mem_en    (mem_en),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .dout_cpu  (dout_cpu),
    .din_cpu   (din_cpu)
  );

  always #5 clk = ~clk;

  // Synchronous read memory: data appears the cycle after the strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) din_cpu <= 16'h0000;
    else if (mem_en && mem_read) din_cpu <= mem[addr_tb];
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  // Releases reset at a falling edge; the next falling edge samples FETCH.
  task automatic start_cpu();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_write(input int budget, output bit found,
                            output logic [11:0] a, output logic [15:0] d);
    found = 1'b0;
    a = '0;
    d = '0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (mem_en && mem_write) begin
        found = 1'b1;
        a = addr_tb;
        d = dout_cpu;
      end
    end
  endtask

  task automatic collect_reads(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (mem_en && mem_read) begin
        fetch_adr[got] = addr_tb;
        fetch_cyc[got] = c;
        got++;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    n_checks++; if (addr_tb !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", addr_tb); end
    n_checks++; if (dout_cpu !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", dout_cpu); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h000 || mem_en !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL first_fetch: got addr=%h en=%b rd=%b wr=%b want 000 1 1 0", addr_tb, mem_en, mem_read, mem_write);
    end
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL decode_idle: got en=%b want 0", mem_en); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h001 || mem_en !== 1'b1 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL nop_next_fetch: got addr=%h en=%b rd=%b want 001 1 1", addr_tb, mem_en, mem_read);
    end
  endtask

  task automatic test_sw_r0();
    clear_mem();
    mem[0] = 16'hB081;
    start_cpu();
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h001 || mem_en !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL sw_mem_cycle: got addr=%h en=%b wr=%b rd=%b want 001 1 1 0", addr_tb, mem_en, mem_write, mem_read);
    end
    n_checks++; if (dout_cpu !== 16'h0000) begin n_fail++; $display("FAIL sw_dout: got %h want 0000", dout_cpu); end
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h001 || mem_read !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL sw_next_fetch: got addr=%h rd=%b want 001 1", addr_tb, mem_read);
    end
  endtask

  task automatic test_alu();
    bit found;
    logic [11:0] a;
    logic [15:0] d;
    alu_prog = '{16'h9305, 16'h9A02, 16'h1C3A, 16'hBC38, 16'h64A3, 16'hB401,
                 16'h753A, 16'hB501, 16'h26A3, 16'hB601, 16'h6763, 16'hB701,
                 16'h886A, 16'hB801, 16'h593A, 16'hB901, 16'h3B63, 16'hBB01,
                 16'h4D6A, 16'hBD01, 16'h9E80, 16'hBE01, 16'h9005, 16'hB001,
                 16'h2300, 16'hB301, 16'h1FDA, 16'hBF01, 16'hF000};
    exp_wa = '{12'hFFD, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001,
               12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001};
    exp_wd = '{16'h0007, 16'h0001, 16'h0014, 16'hFFFD, 16'h0001, 16'h3FFF, 16'h0007,
               16'h0005, 16'hFFFF, 16'hFF80, 16'h0000, 16'h0000, 16'h0001};
    clear_mem();
    for (int i = 0; i < 29; i++) mem[i] = alu_prog[i];
    start_cpu();
    for (int k = 0; k < 13; k++) begin
      wait_write(40, found, a, d);
      n_checks++; if (!found) begin n_fail++; $display("FAIL alu_store_%0d: got no write within 40 cycles, want one", k); end
      n_checks++; if (a !== exp_wa[k]) begin n_fail++; $display("FAIL alu_addr_%0d: got %h want %h", k, a, exp_wa[k]); end
      n_checks++; if (d !== exp_wd[k]) begin n_fail++; $display("FAIL alu_data_%0d: got %h want %h", k, d, exp_wd[k]); end
    end
  endtask

  task automatic test_load();
    bit found;
    logic [11:0] a;
    logic [15:0] d;
    clear_mem();
    mem[0] = 16'hAF05;
    mem[1] = 16'hBF01;
    mem[2] = 16'hF000;
    mem[5] = 16'h1234;
    start_cpu();
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h005 || mem_en !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL lw_mem_cycle: got addr=%h en=%b rd=%b wr=%b want 005 1 1 0", addr_tb, mem_en, mem_read, mem_write);
    end
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL lw_wb_idle: got en=%b want 0", mem_en); end
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h001 || mem_read !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL lw_next_fetch: got addr=%h rd=%b want 001 1", addr_tb, mem_read);
    end
    wait_write(20, found, a, d);
    n_checks++; if (!found || a !== 12'h001 || d !== 16'h1234) begin
      n_fail++; $display("FAIL lw_value: got found=%b addr=%h data=%h want 1 001 1234", found, a, d);
    end
  endtask

  task automatic test_latency();
    int got;
    logic [11:0] ea [7];
    int          ec [7];
    ea = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h005, 12'h004, 12'h005};
    ec = '{0, 4, 8, 12, 15, 17, 20};
    clear_mem();
    mem[0] = 16'h9305;
    mem[1] = 16'h1C3A;
    mem[2] = 16'hB081;
    mem[3] = 16'hAF05;
    mem[4] = 16'h0000;
    mem[5] = 16'hF000;
    start_cpu();
    collect_reads(7, 40, got);
    n_checks++; if (got != 7) begin n_fail++; $display("FAIL lat_reads: got %0d reads want 7", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (fetch_adr[i] !== ea[i]) begin n_fail++; $display("FAIL lat_addr_%0d: got %h want %h", i, fetch_adr[i], ea[i]); end
      n_checks++; if (fetch_cyc[i] - fetch_cyc[0] != ec[i]) begin
        n_fail++; $display("FAIL lat_cycle_%0d: got %0d want %0d", i, fetch_cyc[i] - fetch_cyc[0], ec[i]);
      end
    end
  endtask

  task automatic test_branch_halt();
    int got;
    int en_cnt;
    logic [11:0] ea [10];
    ea = '{12'h000, 12'h001, 12'h002, 12'h010, 12'h00A, 12'h00B, 12'h010, 12'h011, 12'h012, 12'h015};
    clear_mem();
    mem[12'h000] = 16'h9D03;
    mem[12'h001] = 16'h9F04;
    mem[12'h002] = 16'hE010;
    mem[12'h010] = 16'hDDF9;
    mem[12'h00A] = 16'h9FFF;
    mem[12'h00B] = 16'hE010;
    mem[12'h011] = 16'hCD05;
    mem[12'h012] = 16'hCDF2;
    mem[12'h015] = 16'hF000;
    start_cpu();
    collect_reads(10, 80, got);
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL br_fetches: got %0d want 10", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (fetch_adr[i] !== ea[i]) begin n_fail++; $display("FAIL br_addr_%0d: got %h want %h", i, fetch_adr[i], ea[i]); end
    end
    if (got == 10) begin
      n_checks++; if (fetch_cyc[3] - fetch_cyc[2] != 3) begin n_fail++; $display("FAIL jmp_cycles: got %0d want 3", fetch_cyc[3] - fetch_cyc[2]); end
      n_checks++; if (fetch_cyc[4] - fetch_cyc[3] != 3) begin n_fail++; $display("FAIL bne_cycles: got %0d want 3", fetch_cyc[4] - fetch_cyc[3]); end
    end
    en_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
    end
    n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL halt_quiet: got %0d enabled cycles want 0", en_cnt); end
    start_cpu();
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h000 || mem_en !== 1'b1 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart: got addr=%h en=%b rd=%b want 000 1 1", addr_tb, mem_en, mem_read);
    end
  endtask

  task automatic test_pc_wrap();
    int got;
    clear_mem();
    mem[12'h000] = 16'hEFFF;
    mem[12'hFFF] = 16'h0000;
    start_cpu();
    collect_reads(3, 20, got);
    n_checks++; if (got != 3 || fetch_adr[1] !== 12'hFFF || fetch_adr[2] !== 12'h000) begin
      n_fail++; $display("FAIL pc_wrap: got n=%0d %h %h want 3 fff 000", got, fetch_adr[1], fetch_adr[2]);
    end
  endtask

  task automatic test_abort();
    clear_mem();
    mem[0] = 16'hB081;
    start_cpu();
    repeat (4) @(negedge clk);
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL abort_pre_write: got %b want 1", mem_write); end
    reset = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0 || mem_write !== 1'b0 || addr_tb !== 12'h000) begin
      n_fail++; $display("FAIL abort_strobes: got en=%b wr=%b addr=%h want 0 0 000", mem_en, mem_write, addr_tb);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (addr_tb !== 12'h000 || mem_read !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart: got addr=%h rd=%b want 000 1", addr_tb, mem_read);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_sw_r0();
    test_alu();
    test_load();
    test_latency();
    test_branch_halt();
    test_pc_wrap();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
